// File: rtl/bcd_calc_engine.sv
// N-digit BCD calculator core: keyed operand entry, Horner BCD-to-binary,
// add/subtract with sign and overflow, double-dabble back to BCD for display.
module bcd_calc_engine #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_valid,
    input  logic                  is_num,
    input  logic                  is_op,
    input  logic                  is_eq,
    input  logic                  clear,
    input  logic [3:0]            num_val,
    input  logic [1:0]            op_val,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic                  disp_neg,
    output logic                  f_OF,
    output logic                  busy,
    output logic                  is_op1,
    output logic                  is_op2,
    output logic                  is_res,
    output logic                  res_valid
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int STEP_W = $clog2(((DIGITS > BIN_W) ? DIGITS : BIN_W) + 1);
    localparam logic [BIN_W:0] MAXV = (BIN_W + 1)'(10 ** DIGITS - 1);

    typedef enum logic [2:0] {S_OP1, S_OP2, S_CALC, S_ALU, S_CONV, S_RES} state_t;

    state_t                    state;
    logic [BCD_W-1:0]          op1, op2, sh1, sh2, dd;
    logic [CNT_W-1:0]          cnt1, cnt2;
    logic [STEP_W-1:0]         step;
    logic [BIN_W-1:0]          acc1, acc2, mag;
    logic                      op_sub, neg, of;
    logic [BIN_W:0]            sum;
    logic signed [BIN_W:0]     diff;
    logic                      key_digit;

    assign sum       = {1'b0, acc1} + {1'b0, acc2};
    assign diff      = $signed({1'b0, acc1}) - $signed({1'b0, acc2});
    assign key_digit = is_num && (num_val <= 4'd9);

    // {busy, is_op1, is_op2, is_res} for the state being entered
    function automatic logic [3:0] phase_of(input state_t s);
        case (s)
            S_OP1:                 return 4'b0100;
            S_OP2:                 return 4'b0010;
            S_CALC, S_ALU, S_CONV: return 4'b1010;
            default:               return 4'b0001;
        endcase
    endfunction

    // One double-dabble iteration: add 3 to digits >= 5, then shift in a bit
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                     input logic in_bit);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        return {adj[BCD_W-2:0], in_bit};
    endfunction

    function automatic logic [CNT_W-1:0] sig_digits(input logic [BCD_W-1:0] bcd);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd[4*i +: 4] != 4'd0) n = CNT_W'(i + 1);
        return n;
    endfunction

    function automatic logic [BCD_W-1:0] push_digit(input logic [BCD_W-1:0] bcd,
                                                    input logic [3:0] d);
        return (bcd << 4) | BCD_W'(d);
    endfunction

    function automatic logic [BIN_W-1:0] horner(input logic [BIN_W-1:0] acc,
                                                input logic [3:0] d);
        return (acc << 3) + (acc << 1) + BIN_W'(d);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || (key_valid && clear)) begin
            state     <= S_OP1;
            {busy, is_op1, is_op2, is_res} <= phase_of(S_OP1);
            op1       <= '0;
            op2       <= '0;
            sh1       <= '0;
            sh2       <= '0;
            dd        <= '0;
            cnt1      <= '0;
            cnt2      <= '0;
            step      <= '0;
            acc1      <= '0;
            acc2      <= '0;
            mag       <= '0;
            op_sub    <= 1'b0;
            neg       <= 1'b0;
            of        <= 1'b0;
            f_OF      <= 1'b0;
            disp_neg  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_OP1: begin
                    if (key_valid && !is_eq) begin
                        if (is_op) begin
                            if (!op_val[1]) begin
                                op_sub <= op_val[0];
                                op2    <= '0;
                                cnt2   <= '0;
                                state  <= S_OP2;
                                {busy, is_op1, is_op2, is_res} <= phase_of(S_OP2);
                            end
                        end else if (key_digit && cnt1 < CNT_W'(DIGITS)) begin
                            op1  <= push_digit(op1, num_val);
                            cnt1 <= cnt1 + CNT_W'(1);
                        end
                    end
                end
                S_OP2: begin
                    if (key_valid) begin
                        if (is_eq) begin
                            sh1   <= op1;
                            sh2   <= op2;
                            acc1  <= '0;
                            acc2  <= '0;
                            step  <= '0;
                            state <= S_CALC;
                            {busy, is_op1, is_op2, is_res} <= phase_of(S_CALC);
                        end else if (is_op) begin
                            if (!op_val[1]) op_sub <= op_val[0];
                        end else if (key_digit && cnt2 < CNT_W'(DIGITS)) begin
                            op2  <= push_digit(op2, num_val);
                            cnt2 <= cnt2 + CNT_W'(1);
                        end
                    end
                end
                // Horner: both operands, most significant digit first
                S_CALC: begin
                    acc1 <= horner(acc1, sh1[BCD_W-1 -: 4]);
                    acc2 <= horner(acc2, sh2[BCD_W-1 -: 4]);
                    sh1  <= sh1 << 4;
                    sh2  <= sh2 << 4;
                    step <= step + STEP_W'(1);
                    if (step == STEP_W'(DIGITS - 1)) begin
                        state <= S_ALU;
                        {busy, is_op1, is_op2, is_res} <= phase_of(S_ALU);
                    end
                end
                S_ALU: begin
                    if (!op_sub) begin
                        neg <= 1'b0;
                        of  <= (sum > MAXV);
                        mag <= (sum > MAXV) ? MAXV[BIN_W-1:0] : sum[BIN_W-1:0];
                    end else begin
                        of  <= 1'b0;
                        neg <= diff[BIN_W];
                        mag <= diff[BIN_W] ? BIN_W'(-diff) : diff[BIN_W-1:0];
                    end
                    dd    <= '0;
                    step  <= '0;
                    state <= S_CONV;
                    {busy, is_op1, is_op2, is_res} <= phase_of(S_CONV);
                end
                // Double-dabble: one magnitude bit per cycle, MSB first
                S_CONV: begin
                    dd   <= dabble_step(dd, mag[BIN_W-1]);
                    mag  <= mag << 1;
                    step <= step + STEP_W'(1);
                    if (step == STEP_W'(BIN_W - 1)) begin
                        state     <= S_RES;
                        {busy, is_op1, is_op2, is_res} <= phase_of(S_RES);
                        res_valid <= 1'b1;
                        f_OF      <= of;
                        disp_neg  <= neg;
                    end
                end
                S_RES: begin
                    if (key_valid && !is_eq) begin
                        if (is_op) begin
                            // Chain only from a valid, non-negative result
                            if (!op_val[1] && !of && !neg) begin
                                op1      <= dd;
                                cnt1     <= sig_digits(dd);
                                op_sub   <= op_val[0];
                                op2      <= '0;
                                cnt2     <= '0;
                                f_OF     <= 1'b0;
                                disp_neg <= 1'b0;
                                state    <= S_OP2;
                                {busy, is_op1, is_op2, is_res} <= phase_of(S_OP2);
                            end
                        end else if (key_digit) begin
                            op1      <= BCD_W'(num_val);
                            cnt1     <= CNT_W'(1);
                            op2      <= '0;
                            cnt2     <= '0;
                            op_sub   <= 1'b0;
                            of       <= 1'b0;
                            neg      <= 1'b0;
                            f_OF     <= 1'b0;
                            disp_neg <= 1'b0;
                            state    <= S_OP1;
                            {busy, is_op1, is_op2, is_res} <= phase_of(S_OP1);
                        end
                    end
                end
                default: begin
                    state <= S_OP1;
                    {busy, is_op1, is_op2, is_res} <= phase_of(S_OP1);
                end
            endcase
        end
    end

    assign disp_bcd = (state == S_OP1) ? op1 :
                      (state == S_RES) ? dd  : op2;

endmodule

// File: tb/tb_bcd_calc_engine.sv
// Bench for bcd_calc_engine: directed key sequences plus random key streams,
// all checked every cycle against an integer-level calculator model.
module tb_bcd_calc_engine;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int LAT    = DIGITS + BIN_W + 1;
    localparam int MAXV   = 9999;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0, is_num = 1'b0, is_op = 1'b0, is_eq = 1'b0, clear = 1'b0;
    logic [3:0]  num_val = 4'd0;
    logic [1:0]  op_val = 2'd0;
    logic [15:0] disp_bcd;
    logic        disp_neg, f_OF, busy, is_op1, is_op2, is_res, res_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0=entry op1, 1=entry op2, 2=computing, 3=result shown
    int m_ph, m_a, m_na, m_b, m_nb, m_sub, m_r, m_neg, m_of, m_cnt, m_rv;
    int rv_seen;

    bcd_calc_engine #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .is_num(is_num),
        .is_op(is_op), .is_eq(is_eq), .clear(clear), .num_val(num_val),
        .op_val(op_val), .disp_bcd(disp_bcd), .disp_neg(disp_neg), .f_OF(f_OF),
        .busy(busy), .is_op1(is_op1), .is_op2(is_op2), .is_res(is_res),
        .res_valid(res_valid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_clear();
        m_ph = 0; m_a = 0; m_na = 0; m_b = 0; m_nb = 0; m_sub = 0;
        m_r = 0; m_neg = 0; m_of = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        m_rv = 0;
        if (!rst_n || (key_valid && clear)) begin
            model_clear();
        end else begin
            case (m_ph)
                0: if (key_valid && !is_eq) begin
                    if (is_op) begin
                        if (op_val < 2) begin m_sub = op_val; m_b = 0; m_nb = 0; m_ph = 1; end
                    end else if (is_num && num_val <= 9 && m_na < DIGITS) begin
                        m_a = m_a * 10 + num_val; m_na++;
                    end
                end
                1: if (key_valid) begin
                    if (is_eq) begin m_ph = 2; m_cnt = LAT; end
                    else if (is_op) begin
                        if (op_val < 2) m_sub = op_val;
                    end else if (is_num && num_val <= 9 && m_nb < DIGITS) begin
                        m_b = m_b * 10 + num_val; m_nb++;
                    end
                end
                2: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_ph = 3; m_rv = 1; m_of = 0; m_neg = 0;
                        if (m_sub == 0) begin
                            m_r = m_a + m_b;
                            if (m_r > MAXV) begin m_r = MAXV; m_of = 1; end
                        end else begin
                            m_r = m_a - m_b;
                            if (m_r < 0) begin m_r = -m_r; m_neg = 1; end
                        end
                    end
                end
                default: if (key_valid && !is_eq) begin
                    if (is_op) begin
                        if (op_val < 2 && !m_of && !m_neg) begin
                            m_a = m_r; m_sub = op_val; m_b = 0; m_nb = 0;
                            m_of = 0; m_neg = 0; m_ph = 1;
                        end
                    end else if (is_num && num_val <= 9) begin
                        model_clear();
                        m_a = num_val; m_na = 1;
                    end
                end
            endcase
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare 1 time unit later
    task automatic cycle(input logic rst, input logic kv, input logic n, input logic o,
                         input logic e, input logic c, input logic [3:0] nv, input logic [1:0] ov);
        logic [15:0] exp_disp;
        @(negedge clk);
        rst_n = rst; key_valid = kv; is_num = n; is_op = o; is_eq = e; clear = c;
        num_val = nv; op_val = ov;
        @(posedge clk);
        model_step();
        #1;
        exp_disp = (m_ph == 0) ? to_bcd(m_a) : (m_ph == 3) ? to_bcd(m_r) : to_bcd(m_b);
        check_val("cyc_disp", 32'(disp_bcd), 32'(exp_disp));
        check_val("cyc_flags",
                  {25'd0, disp_neg, f_OF, busy, is_op1, is_op2, is_res, res_valid},
                  {25'd0, 1'(m_ph == 3 && m_neg != 0), 1'(m_ph == 3 && m_of != 0), 1'(m_ph == 2),
                   1'(m_ph == 0), 1'(m_ph == 1 || m_ph == 2), 1'(m_ph == 3), 1'(m_rv != 0)});
        if (res_valid) rv_seen++;
    endtask

    task automatic k_num(input int d);   cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'(d), 2'd0); endtask
    task automatic k_op(input int o);    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'(o)); endtask
    task automatic k_eq();               cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0); endtask
    task automatic k_clr();              cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 2'd0); endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    endtask

    logic rr, kk, nn, oo, ee, cc;
    logic [3:0] vv;
    int cls;

    initial begin
        model_clear();
        m_rv = 0;
        rv_seen = 0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 2'd0);
        check_val("rst_disp", 32'(disp_bcd), 32'h0);
        check_val("rst_phase", {28'd0, busy, is_op1, is_op2, is_res}, 32'b0100);

        k_num(1); k_num(2); k_num(3);
        check_val("op1_0123", 32'(disp_bcd), 32'h0123);
        k_op(0); k_num(4); k_num(5);
        check_val("op2_0045", 32'(disp_bcd), 32'h0045);
        k_eq(); idle(LAT - 1);
        check_val("busy_before_res", {30'd0, busy, res_valid}, 32'b10);
        idle(1);
        check_val("sum_0168", 32'(disp_bcd), 32'h0168);
        check_val("sum_flags", {29'd0, res_valid, f_OF, disp_neg}, 32'b100);
        idle(1);
        check_val("rv_one_pulse", 32'(res_valid), 32'd0);

        k_clr(); k_num(1); k_num(2); k_op(1); k_num(5); k_num(0); k_eq(); idle(LAT);
        check_val("sub_0038", 32'(disp_bcd), 32'h0038);
        check_val("sub_neg", 32'(disp_neg), 32'd1);
        k_op(0);
        check_val("neg_no_chain", 32'(is_res), 32'd1);

        k_clr(); for (int i = 0; i < 4; i++) k_num(9);
        k_op(0); k_num(0); k_num(0); k_num(0); k_num(1); k_eq(); idle(LAT);
        check_val("of_9999", {15'd0, f_OF, disp_bcd}, {15'd0, 1'b1, 16'h9999});
        k_num(7);
        check_val("after_of_0007", {14'd0, is_op1, f_OF, disp_bcd}, {14'd0, 1'b1, 1'b0, 16'h0007});

        k_clr(); k_num(2); k_num(0); k_op(0); k_num(5); k_eq(); idle(LAT);
        check_val("chain_0025", 32'(disp_bcd), 32'h0025);
        k_op(1); k_num(3); k_eq(); idle(LAT);
        check_val("chain_0022", {15'd0, disp_neg, disp_bcd}, {15'd0, 1'b0, 16'h0022});
        k_clr(); k_num(8); k_op(0); k_op(1); k_num(2); k_eq(); idle(LAT);
        check_val("oprepl_0006", 32'(disp_bcd), 32'h0006);

        k_clr(); for (int i = 1; i <= 6; i++) k_num(i);
        check_val("sat_1234", 32'(disp_bcd), 32'h1234);
        k_num(12); k_op(2);
        check_val("ignored_keys", {15'd0, is_op1, disp_bcd}, {15'd0, 1'b1, 16'h1234});

        k_clr(); k_num(1); k_op(0); k_num(2); k_eq(); idle(6);
        rv_seen = 0;
        k_clr();
        check_val("clr_busy", {14'd0, busy, is_op1, disp_bcd}, {14'd0, 1'b0, 1'b1, 16'h0});
        idle(LAT + 2);
        check_val("clr_no_rv", 32'(rv_seen), 32'd0);
        k_num(1); k_num(2);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
        check_val("rst_mid_entry", {14'd0, busy, is_op1, disp_bcd}, {14'd0, 1'b0, 1'b1, 16'h0});

        for (int i = 0; i < 4000; i++) begin
            rr  = ($urandom_range(0, 299) != 0);
            kk  = ($urandom_range(0, 99) < 45);
            cls = $urandom_range(0, 99);
            cc  = (cls < 3);
            ee  = (cls >= 3 && cls < 18);
            oo  = (cls >= 18 && cls < 40) || ($urandom_range(0, 19) == 0);
            nn  = (cls >= 40) || ($urandom_range(0, 19) == 0);
            vv  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            cycle(rr, kk, nn, oo, ee, cc, vv, 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
